// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types for the register file slice.
// Default word width, register address width and the hardwired-zero register index.
package mips_pkg;
  localparam int WORD_W = 32;
  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = '0;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard: issue sets busy, any write clears it.
// Issue beats write on the same register so the newest producer stays tracked; r0 never busy.
module rf_scoreboard
  import mips_pkg::*;
#(
  parameter int NREGS = 1 << REG_AW,
  parameter int NWR   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_addr,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] wa,
  output logic [NREGS-1:0]  busy
);

  logic [NREGS-1:1] busy_q;
  logic [NREGS-1:1] set_v;
  logic [NREGS-1:1] clr_v;

  always_comb begin
    set_v = '0;
    clr_v = '0;
    for (int r = 1; r < NREGS; r++) begin
      set_v[r] = iss_valid && (iss_addr == AW'(r));
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && (wa[j*AW +: AW] == AW'(r))) clr_v[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (set_v[r])      busy_q[r] <= 1'b1;
        else if (clr_v[r]) busy_q[r] <= 1'b0;
      end
    end
  end

  assign busy = {busy_q, 1'b0};

endmodule

// File: rtl/mips_regfile_mp.sv
// Multi-port MIPS register file with pending-write scoreboard and RAW stall output.
// Define REGFILE_BYPASS_EN to forward same-cycle write data (and cleared busy) to reads.
module mips_regfile_mp
  import mips_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int NREGS = 1 << REG_AW,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  // Derived from NREGS; not meant to be overridden.
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRD-1:0]       rd_en,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_busy,
  output logic                 stall,
  input  logic [NWR-1:0]       we,
  input  logic [NWR*AW-1:0]    wa,
  input  logic [NWR*WIDTH-1:0] wd,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_addr
);

  localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

  logic [WIDTH-1:0] rf [NREGS];
  logic [NREGS-1:0] busy;

  rf_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR),
    .AW    (AW)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .we        (we),
    .wa        (wa),
    .busy      (busy)
  );

  // Later ports are applied last, so the highest port index wins a collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) rf[r] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && (wa[j*AW +: AW] != ZERO_IDX)) begin
          rf[wa[j*AW +: AW]] <= wd[j*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_comb begin
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
    logic             bsy;
    rd_data = '0;
    rd_busy = '0;
    stall   = 1'b0;
    addr    = '0;
    data    = '0;
    bsy     = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      addr = rd_addr[k*AW +: AW];
      data = rf[addr];
      bsy  = busy[addr];
`ifdef REGFILE_BYPASS_EN
      // A write lost to reset must not be forwarded either.
      if (!reset && (addr != ZERO_IDX)) begin
        for (int j = 0; j < NWR; j++) begin
          if (we[j] && (wa[j*AW +: AW] == addr)) begin
            data = wd[j*WIDTH +: WIDTH];
            bsy  = iss_valid && (iss_addr == addr);
          end
        end
      end
`endif
      rd_data[k*WIDTH +: WIDTH] = data;
      rd_busy[k]                = bsy;
      stall                     = stall | (rd_en[k] & bsy);
    end
  end

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Directed bench for mips_regfile_mp: stimulus queues expectations, a negedge monitor checks them.
module tb_mips_regfile_mp;
  localparam int W  = 32;
  localparam int NR = 32;
  localparam int A  = 5;

  logic           clk;
  logic           reset;
  logic [1:0]     rd_en;
  logic [2*A-1:0] rd_addr;
  logic [2*W-1:0] rd_data;
  logic [1:0]     rd_busy;
  logic           stall;
  logic [1:0]     we;
  logic [2*A-1:0] wa;
  logic [2*W-1:0] wd;
  logic           iss_valid;
  logic [A-1:0]   iss_addr;

  mips_regfile_mp #(.WIDTH(W), .NREGS(NR), .NRD(2), .NWR(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .stall     (stall),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string       name;
    int          port;
    logic [31:0] data;
    logic        busy;
    logic        stl;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Expected read on one port plus the global stall.
  task automatic expect_rd(input string name, input int port, input logic [31:0] d,
                           input logic b, input logic s);
    exp_t e;
    e.name = name; e.port = port; e.data = d; e.busy = b; e.stl = s;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (rd_data[e.port*W +: W] !== e.data || rd_busy[e.port] !== e.busy || stall !== e.stl) begin
        errors++;
        $display("FAIL %s: port%0d data=%h busy=%b stall=%b, want data=%h busy=%b stall=%b",
                 e.name, e.port, rd_data[e.port*W +: W], rd_busy[e.port], stall,
                 e.data, e.busy, e.stl);
      end
    end
  end

  task automatic idle();
    we = '0; wa = '0; wd = '0; iss_valid = 1'b0; iss_addr = '0; rd_en = '0; rd_addr = '0;
  endtask

  task automatic wr(input int j, input int a, input logic [31:0] d);
    we[j] = 1'b1; wa[j*A +: A] = A'(a); wd[j*W +: W] = d;
  endtask

  task automatic rd(input int k, input int a, input logic en);
    rd_en[k] = en; rd_addr[k*A +: A] = A'(a);
  endtask

  task automatic iss(input int a);
    iss_valid = 1'b1; iss_addr = A'(a);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    rd(1, 5, 1'b1);
    #1;
    expect_rd("reset_r0", 0, 32'h0, 1'b0, 1'b0);
    expect_rd("reset_r5", 1, 32'h0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    step();

    // Reset mid-write
    wr(0, 5, 32'hDEADBEEF); iss(5);
    step();
    idle(); rd(1, 5, 1'b1);
    expect_rd("r5_written", 1, 32'hDEADBEEF, 1'b1, 1'b1);
    step();
    wr(0, 5, 32'hCAFEF00D); iss(5); rd(1, 5, 1'b1);
    #1 reset = 1'b1;
    #1;
    expect_rd("reset_mid", 1, 32'h0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    idle(); rd(1, 5, 1'b1);
    expect_rd("after_reset", 1, 32'h0, 1'b0, 1'b0);
    step();

    // Dual write collision, with a same-cycle read of the contested register
    idle();
    wr(0, 7, 32'h11); wr(1, 7, 32'h22); rd(0, 7, 1'b1);
    expect_rd("collide_byp", 0, BYP ? 32'h22 : 32'h0, 1'b0, 1'b0);
    step();
    idle(); rd(0, 7, 1'b1);
    expect_rd("collide_r7", 0, 32'h22, 1'b0, 1'b0);
    step();

    // Register 0
    idle(); wr(0, 0, 32'hFFFFFFFF); iss(0); rd(1, 0, 1'b1);
    expect_rd("r0_same", 1, 32'h0, 1'b0, 1'b0);
    step();
    idle(); rd(0, 0, 1'b1);
    expect_rd("r0_read", 0, 32'h0, 1'b0, 1'b0);
    step();

    // RAW stall
    idle(); iss(3);
    step();
    idle(); rd(0, 3, 1'b0);
    expect_rd("raw_noen", 0, 32'h0, 1'b1, 1'b0);
    step();
    idle(); rd(0, 3, 1'b1);
    expect_rd("raw_c1", 0, 32'h0, 1'b1, 1'b1);
    step();
    idle(); rd(0, 3, 1'b1); wr(1, 3, 32'h1234);
    expect_rd("raw_c2", 0, BYP ? 32'h1234 : 32'h0, !BYP, !BYP);
    step();
    idle(); rd(0, 3, 1'b1);
    expect_rd("raw_c3", 0, 32'h1234, 1'b0, 1'b0);
    step();

    // Issue and write to the same register together
    idle(); iss(9);
    step();
    idle(); wr(0, 9, 32'h99); iss(9); rd(1, 9, 1'b1);
    expect_rd("isswr_same", 1, BYP ? 32'h99 : 32'h0, 1'b1, 1'b1);
    step();
    idle(); rd(1, 9, 1'b1);
    expect_rd("isswr_next", 1, 32'h99, 1'b1, 1'b1);
    step();

    // Bypass data
    idle(); wr(0, 4, 32'h11111111);
    step();
    idle(); wr(1, 4, 32'hA5A5A5A5); rd(1, 4, 1'b1); rd(0, 9, 1'b0);
    expect_rd("byp_same", 1, BYP ? 32'hA5A5A5A5 : 32'h11111111, 1'b0, 1'b0);
    step();
    idle(); rd(0, 4, 1'b1); rd(1, 7, 1'b1);
    expect_rd("byp_next", 0, 32'hA5A5A5A5, 1'b0, 1'b0);
    expect_rd("port1_r7", 1, 32'h22, 1'b0, 1'b0);
    step();

    idle();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
